crc_msg_sequencer: RTL
======================

CRC_MSG_SEQUENCER -- requirements
Module: crc_msg_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: cfg_width  in  7  CRC width in bits (legal 8..64); cfg_poly, cfg_init, cfg_xor  in  64 each  polynomial, initial value, final XOR (LSB-aligned); cfg_refin, cfg_refout  in  1 each  reflect input bytes, reflect result.
REQ-003 SHALL have: start  in  1  pulse, latch cfg and begin a new CRC; fin  in  1  pulse, finalize the current CRC.
REQ-004 SHALL have: in_valid  in  1; in_data  in  8  message byte; in_ready  out  1.
REQ-005 SHALL have: out_valid  out  1; out_data  out  8  result byte; out_last  out  1  final result byte; out_ready  in  1.
REQ-006 SHALL have: busy  out  1  state != IDLE; cfg_err  out  1  one-cycle pulse on rejected start.

Function
REQ-007 SHALL implement FSM states IDLE, ACCUM, SHIFT, FINAL, STREAM.
REQ-008 IDLE: start with legal width -> latch all cfg_* into internal registers, crc <= cfg_init masked to W bits, go ACCUM.
REQ-009 IDLE: start with cfg_width <8 or >64 -> cfg_err=1 for that cycle, stay IDLE, registers unchanged.
REQ-010 ACCUM: in_ready=1; in_valid&in_ready latches byte, shift counter <= 0, go SHIFT.
REQ-011 SHIFT: exactly 8 cycles, one bit per cycle, in_ready=0; bit order MSB-first, or LSB-first if refin latched.
REQ-012 Per bit: fb = crc[W-1] ^ bit; crc <= ((crc << 1) ^ (fb ? poly : 0)) & mask, mask = 2^W-1; after 8th bit go ACCUM (or FINAL if fin pending).
REQ-013 Byte throughput: 1 byte per 9 cycles (1 ACCUM + 8 SHIFT) with in_valid held high.
REQ-014 fin in ACCUM without in_valid -> FINAL next cycle; fin with in_valid in ACCUM -> byte accepted, fin held pending, FINAL after its SHIFT; fin in SHIFT -> pending; fin in IDLE/FINAL/STREAM ignored.
REQ-015 FINAL (1 cycle): res <= (refout ? bit-reverse of crc[W-1:0] : crc) ^ xor, masked; byte count N = ceil(W/8); go STREAM.
REQ-016 STREAM: out_valid=1, out_data = res byte k (k=0 is res[7:0], LSB byte first); k advances on out_valid&out_ready; out_last=1 when k=N-1; handshake at k=N-1 -> IDLE.
REQ-017 out_data/out_valid SHALL be stable while out_valid&!out_ready.
REQ-018 Bits of the top byte above W SHALL output 0.
REQ-019 start in any non-IDLE state SHALL abort current operation and behave as REQ-008/009 (illegal width -> IDLE, cfg_err); start has priority over in_valid, fin, out_ready.
REQ-020 Zero-length message (start then fin) SHALL yield init ^ xor (refout applied).
REQ-021 cfg_* changes after start SHALL not affect the running CRC.

Reset
REQ-022 rst SHALL force IDLE; in_ready, out_valid, out_last, busy, cfg_err, out_data, fin-pending, counters = 0; crc and latched cfg = 0.
REQ-023 rst SHALL take priority over start and all handshakes, any state.

Structure
REQ-024 Shared package SHALL hold: CRC_MAXW=64, state enum, width limits (8, 64).
REQ-025 Single sub-module crc_bit_step (combinational: crc, bit, poly, mask -> next crc) SHALL implement REQ-012.

Verification
REQ-026 CRC-32 (W=32, poly 04C11DB7, init FFFFFFFF, xor FFFFFFFF, refin=refout=1), "123456789" -> bytes 26,39,F4,CB, out_last on CB.
REQ-027 CRC-16/CCITT-FALSE (W=16, poly 1021, init FFFF, xor 0, no refl), "123456789" -> B1,29; in_valid held: 9 cycles/byte.
REQ-028 CRC-8 (W=8, poly 07, init 0, xor 0), "123456789" -> single byte F4 with out_last; out_ready stalled 5 cycles -> data stable.
REQ-029 start with cfg_width=7 -> cfg_err 1 cycle, busy=0; zero-length CRC-32 -> 00,00,00,00.
REQ-030 start mid-SHIFT and rst mid-STREAM -> restart from init / all outputs 0, IDLE next cycle.

Source files
------------

// File: rtl/crc_msg_sequencer_pkg.sv
// Shared types, limits and helpers for the byte-serial configurable CRC sequencer.
package crc_msg_sequencer_pkg;

   localparam int unsigned CRC_MAXW = 64;
   localparam logic [6:0] MIN_W = 7'd8;
   localparam logic [6:0] MAX_W = 7'd64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_SHIFT,
      S_FINAL,
      S_STREAM
   } state_t;

   function automatic logic [CRC_MAXW-1:0] width_mask(input logic [6:0] w);
      return (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

   // Reverse the low w bits of v; bits above w come out zero.
   function automatic logic [CRC_MAXW-1:0] reflect_w(input logic [CRC_MAXW-1:0] v,
                                                    input logic [6:0] w);
      logic [CRC_MAXW-1:0] r;
      for (int i = 0; i < CRC_MAXW; i++) r[i] = v[CRC_MAXW-1-i];
      return r >> (MAX_W - w);
   endfunction

   function automatic logic [3:0] byte_count(input logic [6:0] w);
      return w[6:3] + {3'b000, |w[2:0]};
   endfunction

endpackage

// File: rtl/crc_msg_sequencer_bit_step.sv
// One bit of the CRC shift register: feedback from the MSB selected by the width mask.
module crc_bit_step
   import crc_msg_sequencer_pkg::*;
(
   input  logic [CRC_MAXW-1:0] crc,
   input  logic                din,
   input  logic [CRC_MAXW-1:0] poly,
   input  logic [CRC_MAXW-1:0] mask,
   output logic [CRC_MAXW-1:0] crc_next
);

   logic [CRC_MAXW-1:0] top_bit;
   logic                fb;

   // mask ^ (mask >> 1) leaves only bit W-1 set, so no width port is needed.
   assign top_bit  = mask ^ (mask >> 1);
   assign fb       = (|(crc & top_bit)) ^ din;
   assign crc_next = ((crc << 1) ^ (fb ? poly : '0)) & mask;

endmodule

// File: rtl/crc_msg_sequencer.sv
// Configurable-width CRC engine: accepts message bytes, shifts one bit per cycle,
// then streams the finalized result LSB byte first.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_ACCUM  | ready for a message byte or fin
// S_SHIFT  | clocking 8 bits of the latched byte into the CRC
// S_FINAL  | apply reflect-out and final XOR
// S_STREAM | presenting result bytes on the output handshake
module crc_msg_sequencer
   import crc_msg_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          cfg_width,
   input  logic [CRC_MAXW-1:0] cfg_poly,
   input  logic [CRC_MAXW-1:0] cfg_init,
   input  logic [CRC_MAXW-1:0] cfg_xor,
   input  logic                cfg_refin,
   input  logic                cfg_refout,
   input  logic                start,
   input  logic                fin,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   output logic                in_ready,
   output logic                out_valid,
   output logic [7:0]          out_data,
   output logic                out_last,
   input  logic                out_ready,
   output logic                busy,
   output logic                cfg_err
);

   state_t              state;
   logic [6:0]          width_q;
   logic [CRC_MAXW-1:0] poly_q, xor_q, mask_q, crc_q, res_q;
   logic                refin_q, refout_q, fin_pend;
   logic [7:0]          byte_q;
   logic [2:0]          bit_cnt;
   logic [3:0]          byte_idx, nbytes_q;

   logic                cfg_ok, bit_sel;
   logic [CRC_MAXW-1:0] cfg_mask, crc_next, res_next;

   assign cfg_ok   = (cfg_width >= MIN_W) && (cfg_width <= MAX_W);
   assign cfg_mask = width_mask(cfg_width);
   assign bit_sel  = refin_q ? byte_q[bit_cnt] : byte_q[3'd7 - bit_cnt];
   assign res_next = ((refout_q ? reflect_w(crc_q, width_q) : crc_q) ^ xor_q) & mask_q;

   crc_bit_step u_bit_step (
      .crc      (crc_q),
      .din      (bit_sel),
      .poly     (poly_q),
      .mask     (mask_q),
      .crc_next (crc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         width_q   <= '0;
         poly_q    <= '0;
         xor_q     <= '0;
         mask_q    <= '0;
         crc_q     <= '0;
         res_q     <= '0;
         refin_q   <= 1'b0;
         refout_q  <= 1'b0;
         fin_pend  <= 1'b0;
         byte_q    <= '0;
         bit_cnt   <= '0;
         byte_idx  <= '0;
         nbytes_q  <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         if (start) begin
            // start overrides everything, including an in-flight message
            if (cfg_ok) begin
               width_q  <= cfg_width;
               poly_q   <= cfg_poly;
               xor_q    <= cfg_xor;
               mask_q   <= cfg_mask;
               refin_q  <= cfg_refin;
               refout_q <= cfg_refout;
               nbytes_q <= byte_count(cfg_width);
               crc_q    <= cfg_init & cfg_mask;
               state    <= S_ACCUM;
               in_ready <= 1'b1;
               busy     <= 1'b1;
            end else begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               cfg_err  <= 1'b1;
            end
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            fin_pend  <= 1'b0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
         end else begin
            case (state)
               S_IDLE: ;
               S_ACCUM: begin
                  if (in_valid) begin
                     byte_q   <= in_data;
                     bit_cnt  <= '0;
                     fin_pend <= fin;
                     in_ready <= 1'b0;
                     state    <= S_SHIFT;
                  end else if (fin) begin
                     in_ready <= 1'b0;
                     state    <= S_FINAL;
                  end
               end
               S_SHIFT: begin
                  crc_q   <= crc_next;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (fin) fin_pend <= 1'b1;
                  if (bit_cnt == 3'd7) begin
                     if (fin_pend || fin) begin
                        fin_pend <= 1'b0;
                        state    <= S_FINAL;
                     end else begin
                        in_ready <= 1'b1;
                        state    <= S_ACCUM;
                     end
                  end
               end
               S_FINAL: begin
                  res_q     <= res_next;
                  out_data  <= res_next[7:0];
                  out_valid <= 1'b1;
                  out_last  <= (nbytes_q == 4'd1);
                  byte_idx  <= '0;
                  state     <= S_STREAM;
               end
               S_STREAM: begin
                  if (out_ready) begin
                     if (byte_idx == nbytes_q - 4'd1) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                     end else begin
                        byte_idx <= byte_idx + 4'd1;
                        out_data <= res_q[{byte_idx[2:0] + 3'd1, 3'b000} +: 8];
                        out_last <= (byte_idx + 4'd2 == nbytes_q);
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
